axi4_burst_master: RTL

//   Parametrised AXI4 self-test master: on start, writes one INCR burst of

---
 rtl/axi4_burst_master.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_master.sv
// AXI4 self-test master: writes one INCR burst of SEED+i, waits for B, reads the
// burst back and flags any response, data or RLAST-placement error (sticky).
module axi4_burst_master #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       BURST_LEN = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0004,
  parameter logic [31:0]       SEED      = 32'h1234_5678
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam logic [2:0]        SIZE      = 3'($clog2(DATA_W / 8));
  localparam logic [7:0]        LEN       = 8'(BURST_LEN - 1);
  localparam logic [8:0]        LAST_BEAT = 9'(BURST_LEN - 1);
  localparam logic [DATA_W-1:0] SEED_D    = DATA_W'(SEED);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_WAIT_B = 3'd2;
  localparam logic [2:0] S_READ_A = 3'd3;
  localparam logic [2:0] S_READ_D = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_awaddr;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_wlast;
  logic [DATA_W-1:0] r_wdata;
  logic [8:0]        r_wbeat;
  logic              r_aw_done;
  logic              r_w_done;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  logic [8:0]        r_rbeat;
  logic              r_done;
  logic              r_error;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_fin;
  logic              w_w_fin;
  logic              w_r_hs;
  logic [8:0]        w_wbeat_nx;
  logic [DATA_W-1:0] w_rexp;
  logic              w_rbad;

  assign w_aw_hs    = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs     = r_wvalid & M_AXI_WREADY;
  // AW and W complete independently; either may arrive first or in the same cycle
  assign w_aw_fin   = r_aw_done | w_aw_hs;
  assign w_w_fin    = r_w_done | (w_w_hs & r_wlast);
  assign w_r_hs     = M_AXI_RVALID & r_rready;
  assign w_wbeat_nx = r_wbeat + 9'd1;
  assign w_rexp     = SEED_D + DATA_W'(r_rbeat);
  assign w_rbad     = (M_AXI_RDATA != w_rexp) | (M_AXI_RRESP != 2'b00) |
                      (M_AXI_RLAST != (r_rbeat == LAST_BEAT));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_wdata   <= '0;
      r_wbeat   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rbeat   <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_awaddr  <= BASE_ADDR;
            r_araddr  <= BASE_ADDR;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wdata   <= SEED_D;
            r_wlast   <= (BURST_LEN == 1);
            r_wbeat   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_w_done <= 1'b1;
            end else begin
              r_wbeat <= w_wbeat_nx;
              r_wdata <= SEED_D + DATA_W'(w_wbeat_nx);
              r_wlast <= (w_wbeat_nx == LAST_BEAT);
            end
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (M_AXI_BVALID) begin
            r_bready  <= 1'b0;
            r_error   <= r_error | (M_AXI_BRESP != 2'b00);
            r_arvalid <= 1'b1;
            r_state   <= S_READ_A;
          end
        end
        S_READ_A: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rbeat   <= '0;
            r_state   <= S_READ_D;
          end
        end
        S_READ_D: begin
          if (w_r_hs) begin
            r_error <= r_error | w_rbad;
            r_rbeat <= r_rbeat + 9'd1;
            // an early RLAST or a missing one both end the burst; w_rbad records why
            if (M_AXI_RLAST || (r_rbeat == LAST_BEAT)) begin
              r_rready <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done          = r_done;
  assign error         = r_error;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = LEN;
  assign M_AXI_AWSIZE  = SIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = r_wlast;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARLEN   = LEN;
  assign M_AXI_ARSIZE  = SIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule
